// File: rtl/divider.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU: one quotient bit per cycle,
// sign fix-up on completion, result held while start stays high.
module divider #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opv1,
  input  logic [DATA_W-1:0]     opv2,
  input  logic                  cancel,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, DIVZERO, RUN, DONE} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rem_q, quo_q, div_q;
  logic                negq_q, negr_q;
  logic                ready_q, busy_q;
  logic [2*DATA_W-1:0] result_q;

  logic [DATA_W:0]     r_sh, diff;
  logic [DATA_W-1:0]   rem_d, quo_d, q_fix, r_fix, abs1, abs2;

  always_comb begin
    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // r_sh < 2*div_q, so the difference always fits DATA_W+1 bits signed.
    r_sh  = {rem_q, quo_q[DATA_W-1]};
    diff  = r_sh - {1'b0, div_q};
    rem_d = diff[DATA_W] ? r_sh[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_d = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
    q_fix = negq_q ? (~quo_q + 1'b1) : quo_q;
    r_fix = negr_q ? (~rem_q + 1'b1) : rem_q;
    abs1  = (signed_div && opv1[DATA_W-1]) ? (~opv1 + 1'b1) : opv1;
    abs2  = (signed_div && opv2[DATA_W-1]) ? (~opv2 + 1'b1) : opv2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else if (cancel) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            negq_q  <= signed_div & (opv1[DATA_W-1] ^ opv2[DATA_W-1]);
            negr_q  <= signed_div & opv1[DATA_W-1];
            quo_q   <= abs1;
            div_q   <= abs2;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (opv2 == '0) ? DIVZERO : RUN;
          end
        end
        DIVZERO: begin
          // One stall cycle, then one more edge before the zero result is presented.
          if (cnt_q == '0) begin
            busy_q <= 1'b0;
            cnt_q  <= cnt_q + 1'b1;
          end else begin
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        RUN: begin
          if (cnt_q == CNT_W'(DATA_W)) begin
            result_q <= {r_fix, q_fix};
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule
